i2c_target_regbank: RTL and testbench

- I2C target (slave) that sits on the same open-drain sda/scl bus downstream of the team's I2C master and consumes its transactions.
- Write transactions: each data byte is captured and published as a one-cycle strobe for a write-side register bank.
- Read transactions: bytes are served from a parallel read bank.
- The block matches one 7-bit address and never stretches scl.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_line_filter.sv | 57 +++++
 rtl/i2c_target_regbank.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_target_regbank.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bank.
package i2c_pkg;

    localparam int I2C_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, FILT-sample glitch filter and edge pulses for one bus line.
module i2c_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT + 1);

    logic          sync1_q, sync2_q, filt_q, rise_q, fall_q;
    logic          filt_d, rise_d, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered line only follows after FILT consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
    end

    // Idle bus level is high, so the pipeline resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign line_out = filt_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target: publishes written bytes as strobes and serves reads from a parallel byte bank.
module i2c_target_regbank
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_WR     = 5,
    parameter int         NUM_RD     = 4,
    parameter int         FILT       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scl,
    inout  wire                          sda,
    input  logic [I2C_BITS*NUM_RD-1:0]   rd_bank,
    output logic                         wr_valid,
    output logic [2:0]                   wr_index,
    output logic [I2C_BITS-1:0]          wr_data,
    output logic                         rd_strobe,
    output logic [2:0]                   rd_index,
    output logic                         busy,
    output logic                         done
);

    localparam int RIW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk      (clk),
        .rst      (rst),
        .line_in  (scl),
        .line_out (scl_f),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk      (clk),
        .rst      (rst),
        .line_in  (sda),
        .line_out (sda_f),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    logic [I2C_BITS-1:0] rd_bytes [NUM_RD];

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_bytes
        assign rd_bytes[gi] = rd_bank[I2C_BITS*gi +: I2C_BITS];
    end

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [I2C_BITS-1:0] shift_q, shift_d;
    logic [I2C_BITS-1:0] tx_q, tx_d;
    logic                got_q, got_d;
    logic                rw_q, rw_d;
    logic                ack_q, ack_d;
    logic                sda_oe_q, sda_oe_d;
    logic                addressed_q, addressed_d;
    logic [2:0]          wr_cnt_q, wr_cnt_d;
    logic [RIW-1:0]      rd_idx_q, rd_idx_d, rd_next;
    logic                wr_valid_q, wr_valid_d;
    logic [2:0]          wr_index_q, wr_index_d;
    logic [I2C_BITS-1:0] wr_data_q, wr_data_d;
    logic                rd_strobe_q, rd_strobe_d;
    logic [2:0]          rd_index_q, rd_index_d;
    logic                done_q, done_d;

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        got_d       = got_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        addressed_d = addressed_q;
        wr_cnt_d    = wr_cnt_q;
        rd_idx_d    = rd_idx_q;
        wr_valid_d  = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        rd_strobe_d = 1'b0;
        rd_index_d  = rd_index_q;
        done_d      = 1'b0;
        rd_next     = (rd_idx_q == RIW'(NUM_RD - 1)) ? '0 : rd_idx_q + 1'b1;

        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd7;
            shift_d     = '0;
            got_d       = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            sda_oe_d    = 1'b0;
            done_d      = addressed_q;
            addressed_d = 1'b0;
        end else begin
            // Incoming bits are sampled on the rising edge of scl.
            if (scl_rise && (state_q == ADDR || state_q == WRITE)) begin
                shift_d = {shift_q[I2C_BITS-2:0], sda_f};
                if (bit_cnt_q == 3'd0) begin
                    got_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            if (scl_rise && state_q == READ_ACK) begin
                ack_d = sda_f;
            end

            if (scl_fall) begin
                case (state_q)
                    ADDR: begin
                        if (got_q) begin
                            got_d = 1'b0;
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_d    = 1'b1;
                                rw_d        = shift_q[0];
                                addressed_d = 1'b1;
                                state_d     = ADDR_ACK;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt_d = 3'd7;
                        if (!rw_q) begin
                            sda_oe_d = 1'b0;
                            wr_cnt_d = '0;
                            state_d  = WRITE;
                        end else begin
                            rd_idx_d    = '0;
                            rd_strobe_d = 1'b1;
                            rd_index_d  = '0;
                            tx_d        = rd_bytes[0];
                            sda_oe_d    = ~rd_bytes[0][I2C_BITS-1];
                            state_d     = READ;
                        end
                    end
                    WRITE: begin
                        if (got_q) begin
                            got_d = 1'b0;
                            if (wr_cnt_q < 3'(NUM_WR)) begin
                                wr_valid_d = 1'b1;
                                wr_data_d  = shift_q;
                                wr_index_d = wr_cnt_q;
                                sda_oe_d   = 1'b1;
                            end else begin
                                sda_oe_d = 1'b0;
                            end
                            state_d = WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd7;
                        if (wr_cnt_q < 3'(NUM_WR)) begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                        state_d = WRITE;
                    end
                    READ: begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = READ_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                            tx_d      = {tx_q[I2C_BITS-2:0], 1'b0};
                            sda_oe_d  = ~tx_q[I2C_BITS-2];
                        end
                    end
                    READ_ACK: begin
                        if (!ack_q) begin
                            rd_idx_d    = rd_next;
                            rd_strobe_d = 1'b1;
                            rd_index_d  = 3'(rd_next);
                            tx_d        = rd_bytes[rd_next];
                            sda_oe_d    = ~rd_bytes[rd_next][I2C_BITS-1];
                            bit_cnt_d   = 3'd7;
                            state_d     = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            got_q       <= 1'b0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            addressed_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_idx_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            rd_index_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            got_q       <= got_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            addressed_q <= addressed_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_idx_q    <= rd_idx_d;
            wr_valid_q  <= wr_valid_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            rd_strobe_q <= rd_strobe_d;
            rd_index_q  <= rd_index_d;
            done_q      <= done_d;
        end
    end

    // Open-drain: only ever pull low, otherwise release the line.
    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid  = wr_valid_q;
    assign wr_index  = wr_index_q;
    assign wr_data   = wr_data_q;
    assign rd_strobe = rd_strobe_q;
    assign rd_index  = rd_index_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Bit-banged I2C master driving the target, with strobe scoreboards and table-driven byte checks.
module tb_i2c_target_regbank;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic [31:0] rd_bank = 32'hDDCCBBAA;
    wire         sda;
    logic        wr_valid, rd_strobe, busy, done;
    logic [2:0]  wr_index, rd_index;
    logic [7:0]  wr_data;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_regbank dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .rd_bank   (rd_bank),
        .wr_valid  (wr_valid),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .rd_index  (rd_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0, rd_seen = 0, done_cnt = 0, drive_cnt = 0;

    typedef struct packed { logic [2:0] idx; logic [7:0] data; } wr_exp_t;
    wr_exp_t    wr_q [$];
    logic [2:0] rd_q [$];
    wr_exp_t    we;
    logic [2:0] re;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: sample DUT outputs 3 ns after the active edge.
    always @(posedge clk) begin
        #3;
        if (sda === 1'b0 && !m_low) drive_cnt++;
        if (done) done_cnt++;
        if (wr_valid) begin
            wr_seen++;
            $display("wr strobe idx %0d data %02h", wr_index, wr_data);
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_strobe: got idx %0d data %02h, expected no strobe", wr_index, wr_data);
            end else begin
                we = wr_q.pop_front();
                chk("wr_strobe", {21'd0, wr_index, wr_data}, {21'd0, we.idx, we.data});
            end
        end
        if (rd_strobe) begin
            rd_seen++;
            $display("rd strobe idx %0d", rd_index);
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_strobe: got idx %0d, expected no strobe", rd_index);
            end else begin
                re = rd_q.pop_front();
                chk("rd_strobe_idx", {29'd0, rd_index}, {29'd0, re});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, input logic glitch, output logic r);
        m_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        if (glitch) begin
            m_low = ~m_low;
            wait_clk(1);
            m_low = ~m_low;
        end
        r = sda;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch && (i == 7), r);
        bit_xfer(1'b1, 1'b0, r);
        acked = ~r;
        $display("master wrote %02h, target ack %0b", b, acked);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, r);
            d[i] = r;
        end
        bit_xfer(nack, 1'b0, r);
        $display("master read %02h, master nack %0b", d, nack);
    endtask

    typedef struct { logic [7:0] b; logic exp_ack; logic strobe; logic [2:0] idx; } wvec_t;
    typedef struct { logic [7:0] exp; logic nack; } rvec_t;

    wvec_t wt [7];
    rvec_t rt [4];

    initial begin
        logic       acked, r;
        logic [7:0] d;
        int         d0, w0, r0, v0;

        wt[0] = '{8'hA0, 1'b1, 1'b0, 3'd0};
        wt[1] = '{8'h11, 1'b1, 1'b1, 3'd0};
        wt[2] = '{8'h22, 1'b1, 1'b1, 3'd1};
        wt[3] = '{8'h33, 1'b1, 1'b1, 3'd2};
        wt[4] = '{8'h44, 1'b1, 1'b1, 3'd3};
        wt[5] = '{8'h55, 1'b1, 1'b1, 3'd4};
        wt[6] = '{8'h66, 1'b0, 1'b0, 3'd0};
        rt[0] = '{8'hAA, 1'b0};
        rt[1] = '{8'hBB, 1'b0};
        rt[2] = '{8'hCC, 1'b0};
        rt[3] = '{8'hDD, 1'b1};

        wait_clk(5);
        chk("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("reset_wr_index", {29'd0, wr_index}, 32'd0);
        chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
        chk("reset_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        chk("reset_rd_index", {29'd0, rd_index}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sda", {31'd0, sda}, 32'd1);
        rst = 1'b1;
        wait_clk(10);

        // Write five bytes plus one over-length byte.
        d0 = done_cnt; w0 = wr_seen;
        bus_start();
        for (int i = 0; i < 7; i++) begin
            if (wt[i].strobe) wr_q.push_back('{wt[i].idx, wt[i].b});
            write_byte(wt[i].b, 1'b0, acked);
            chk($sformatf("write_ack_%0d", i), {31'd0, acked}, {31'd0, wt[i].exp_ack});
        end
        bus_stop();
        chk("write_strobe_count", wr_seen - w0, 5);
        chk("write_done", done_cnt - d0, 1);
        chk("write_queue_empty", wr_q.size(), 0);
        chk("write_busy_after_stop", {31'd0, busy}, 32'd0);

        // Read four bytes; byte 0 in the bank changes after it is loaded.
        d0 = done_cnt; r0 = rd_seen;
        for (int i = 0; i < 4; i++) rd_q.push_back(3'(i));
        bus_start();
        write_byte(8'hA1, 1'b0, acked);
        chk("read_addr_ack", {31'd0, acked}, 32'd1);
        rd_bank[7:0] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            read_byte(rt[i].nack, d);
            chk($sformatf("read_byte_%0d", i), {24'd0, d}, {24'd0, rt[i].exp});
        end
        wait_clk(2);
        chk("read_busy_after_nack", {31'd0, busy}, 32'd0);
        bus_stop();
        chk("read_strobe_count", rd_seen - r0, 4);
        chk("read_queue_empty", rd_q.size(), 0);
        chk("read_done", done_cnt - d0, 1);

        // Wrong address.
        d0 = done_cnt; w0 = wr_seen; r0 = rd_seen; v0 = drive_cnt;
        bus_start();
        write_byte(8'hA2, 1'b0, acked);
        chk("badaddr_nack", {31'd0, acked}, 32'd0);
        wait_clk(4);
        chk("badaddr_busy", {31'd0, busy}, 32'd0);
        bus_stop();
        chk("badaddr_sda_driven", drive_cnt - v0, 0);
        chk("badaddr_strobes", (wr_seen - w0) + (rd_seen - r0), 0);
        chk("badaddr_done", done_cnt - d0, 0);

        // Repeated start: write one byte, then read from index 0.
        rd_bank = 32'hDDCCBBAA;
        d0 = done_cnt;
        wr_q.push_back('{3'd0, 8'h01});
        rd_q.push_back(3'd0);
        bus_start();
        write_byte(8'hA0, 1'b0, acked);
        chk("rs_waddr_ack", {31'd0, acked}, 32'd1);
        write_byte(8'h01, 1'b0, acked);
        chk("rs_wdata_ack", {31'd0, acked}, 32'd1);
        bus_start();
        write_byte(8'hA1, 1'b0, acked);
        chk("rs_raddr_ack", {31'd0, acked}, 32'd1);
        read_byte(1'b1, d);
        chk("rs_read_byte", {24'd0, d}, 32'hAA);
        bus_stop();
        chk("rs_done", done_cnt - d0, 1);
        chk("rs_queues_empty", wr_q.size() + rd_q.size(), 0);

        // Reset while the target drives bit 3 (a zero) of a read byte.
        rd_bank[7:0] = 8'hF0;
        rd_q.push_back(3'd0);
        bus_start();
        write_byte(8'hA1, 1'b0, acked);
        chk("rst_addr_ack", {31'd0, acked}, 32'd1);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, r);
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        chk("rst_pre_sda_driven", {31'd0, sda}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_sda_released", {31'd0, sda}, 32'd1);
        chk("rst_outputs", {20'd0, wr_valid, wr_index, wr_data}, 32'd0);
        chk("rst_rd_outputs", {27'd0, rd_strobe, rd_index, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        wait_clk(Q);
        rst = 1'b1;
        wait_clk(Q);
        d0 = done_cnt;
        wr_q.push_back('{3'd0, 8'h5A});
        bus_start();
        write_byte(8'hA0, 1'b0, acked);
        chk("post_rst_addr_ack", {31'd0, acked}, 32'd1);
        write_byte(8'h5A, 1'b0, acked);
        chk("post_rst_data_ack", {31'd0, acked}, 32'd1);
        bus_stop();
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_queues_empty", wr_q.size() + rd_q.size(), 0);

        // Glitches: a 1-clk low pulse while idle, a 1-clk high pulse mid-write.
        m_low = 1'b1;
        wait_clk(1);
        m_low = 1'b0;
        wait_clk(Q);
        chk("glitch_idle_busy", {31'd0, busy}, 32'd0);
        d0 = done_cnt;
        wr_q.push_back('{3'd0, 8'h3C});
        bus_start();
        write_byte(8'hA0, 1'b0, acked);
        chk("glitch_addr_ack", {31'd0, acked}, 32'd1);
        write_byte(8'h3C, 1'b1, acked);
        chk("glitch_data_ack", {31'd0, acked}, 32'd1);
        bus_stop();
        chk("glitch_done", done_cnt - d0, 1);
        chk("glitch_queue_empty", wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
